// File: rtl/cwru_tx_key_framer.sv
// cwru_tx_key_framer: queued active-low key presses sent as framed serial codes, MSB first; define CWRU_TX_PARITY_EN to add an even-parity bit
module cwru_tx_key_framer #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W = 8,
  parameter int DIV = 4,
  parameter logic [NUM_KEYS*CODE_W-1:0] CODE_TABLE = 32'hE1B2741D,
  localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1,
  localparam int BW = $clog2(CODE_W + 3)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic                ser_out,
  output logic                bit_clk_out,
  output logic                busy,
  output logic [KW-1:0]       cur_key,
  output logic [BW-1:0]       bit_cnt,
  output logic [NUM_KEYS-1:0] pending,
  output logic                frame_done,
  output logic                overrun,
  output logic [6:0]          HEX0
);
  localparam int DW = $clog2(DIV);
`ifdef CWRU_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_nxt;
  logic [NUM_KEYS-1:0] s1, s2, s3, press, clr;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_nxt;
  logic [CODE_W-1:0] shift_reg, shift_nxt;
  logic [KW-1:0] k, key_nxt;
  logic wrap, load;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= KEY;
      s2 <= s1;
      s3 <= s2;
    end
  assign press = s3 & ~s2;
  always_comb begin
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pending[i]) k = KW'(i);
  end
  assign wrap = div_cnt == DW'(DIV - 1);
  assign load = state == IDLE && |pending;
  assign clr = load ? NUM_KEYS'(1) << k : '0;
  always_comb begin
    state_nxt = state;
    div_nxt = wrap ? '0 : div_cnt + 1'b1;
    bit_nxt = bit_cnt;
    shift_nxt = shift_reg;
    key_nxt = cur_key;
    case (state)
      IDLE: begin
        div_nxt = '0;
        if (load) begin
          state_nxt = START;
          shift_nxt = CODE_TABLE[k*CODE_W +: CODE_W];
          key_nxt = k;
        end
      end
      START: if (wrap) begin
        state_nxt = DATA;
        bit_nxt = bit_cnt + 1'b1;
      end
      DATA: if (wrap) begin
        shift_nxt = shift_reg << 1;
        bit_nxt = bit_cnt + 1'b1;
`ifdef CWRU_TX_PARITY_EN
        if (bit_cnt == BW'(CODE_W)) state_nxt = PAR;
`else
        if (bit_cnt == BW'(CODE_W)) state_nxt = STOP;
`endif
      end
`ifdef CWRU_TX_PARITY_EN
      PAR: if (wrap) begin
        state_nxt = STOP;
        bit_nxt = bit_cnt + 1'b1;
      end
`endif
      STOP: if (wrap) begin
        state_nxt = IDLE;
        bit_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      cur_key <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shift_reg <= shift_nxt;
      cur_key <= key_nxt;
      pending <= (pending & ~clr) | press;
      overrun <= overrun | |(press & pending & ~clr);
    end
  // outputs decode straight from state so reset forces the line idle without a clock
`ifdef CWRU_TX_PARITY_EN
  assign ser_out = state == START ? 1'b0 : state == DATA ? shift_reg[CODE_W-1] :
                   state == PAR ? ^CODE_TABLE[cur_key*CODE_W +: CODE_W] : 1'b1;
`else
  assign ser_out = state == START ? 1'b0 : state == DATA ? shift_reg[CODE_W-1] : 1'b1;
`endif
  assign busy = state != IDLE;
  assign bit_clk_out = busy && div_cnt < DW'(DIV / 2);
  assign frame_done = state == STOP && wrap;
  always_comb
    case (4'(cur_key))
      4'h0: HEX0 = 7'b1000000;
      4'h1: HEX0 = 7'b1111001;
      4'h2: HEX0 = 7'b0100100;
      4'h3: HEX0 = 7'b0110000;
      4'h4: HEX0 = 7'b0011001;
      4'h5: HEX0 = 7'b0010010;
      4'h6: HEX0 = 7'b0000010;
      4'h7: HEX0 = 7'b1111000;
      4'h8: HEX0 = 7'b0000000;
      4'h9: HEX0 = 7'b0010000;
      4'hA: HEX0 = 7'b0001000;
      4'hB: HEX0 = 7'b0000011;
      4'hC: HEX0 = 7'b1000110;
      4'hD: HEX0 = 7'b0100001;
      4'hE: HEX0 = 7'b0000110;
      default: HEX0 = 7'b0001110;
    endcase
endmodule
